// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable multi-channel clock divider.
package clk_div_pkg;

    localparam int NUM_CH_DEF = 2;
    localparam int DIV_W_DEF  = 8;

    typedef logic [DIV_W_DEF-1:0] div_t;

    // Length of the low phase for divisor n: ceil(n/2). Widened so n = 2^W-1 cannot overflow.
    function automatic int unsigned low_len(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor and registered clk_out/tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    logic [DIV_W-1:0] cnt, div_act, div_pend, cnt_next;
    logic             running, wrap, apply_now;

    always_comb begin
        running   = en && (div_act > DIV_W'(1));
        wrap      = running && (cnt >= div_act - DIV_W'(1));
        cnt_next  = wrap ? '0 : cnt + DIV_W'(1);
        // A new divisor lands only on a period boundary or when nothing is toggling.
        apply_now = pend && (wrap || (div_act <= DIV_W'(1)) || !en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            div_act  <= DIV_W'(DEFAULT_DIV);
            div_pend <= '0;
            pend     <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= en && (wrap || (div_act == DIV_W'(1)));
            if (apply_now) begin
                div_act <= div_pend;
                cnt     <= '0;
                clk_out <= 1'b0;
                pend    <= 1'b0;
            end else if (running) begin
                cnt     <= cnt_next;
                clk_out <= 32'(cnt_next) >= low_len(32'(div_act));
            end else if (div_act <= DIV_W'(1)) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end
            if (wr) begin
                div_pend <= wr_div;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: config decode, ready mux and channel array.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = NUM_CH_DEF,
    parameter  int DIV_W       = DIV_W_DEF,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pend, wr;

    // Out-of-range channels stay ready so their writes are swallowed.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .pend    (pend[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-edge expected waveforms written out by hand.
module tb_clk_div_prog;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset, en, cfg_valid, cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] clk_out, tick;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        step; step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [NUM_CH-1:0] ec, et;
        reset = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        for (int i = 0; i < 2; i++) begin
            step;
            checks++;
            if (clk_out !== 3'b000 || tick !== 3'b000) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d clk_out=%b tick=%b want 000/000", i, clk_out, tick);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step;
            ec = (i % 2 == 0) ? 3'b111 : 3'b000;
            et = (i % 2 == 0) ? 3'b000 : 3'b111;
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errors++;
                $display("FAIL reset_div2 edge%0d clk_out=%b tick=%b want %b/%b", i+1, clk_out, tick, ec, et);
            end
        end
    endtask

    task automatic test_idle_write;
        logic [0:8] c1 = 9'b010010010, t1 = 9'b101001001;
        logic [0:8] c0 = 9'b010101010, t0 = 9'b101010101;
        do_reset;
        step;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got %b want 1", cfg_ready);
        end
        for (int i = 0; i < 9; i++) begin
            step;
            if (i == 0) cfg_valid = 1'b0;
            checks++;
            if (clk_out[1] !== c1[i] || tick[1] !== t1[i]) begin
                errors++;
                $display("FAIL idle_ch1 edge%0d clk_out=%b tick=%b want %b/%b", i+2, clk_out[1], tick[1], c1[i], t1[i]);
            end
            checks++;
            if (clk_out[0] !== c0[i] || tick[0] !== t0[i]) begin
                errors++;
                $display("FAIL idle_ch0 edge%0d clk_out=%b tick=%b want %b/%b", i+2, clk_out[0], tick[0], c0[i], t0[i]);
            end
        end
    endtask

    task automatic test_deferred_apply;
        logic [0:15] ec = 16'b1001100110001110;
        logic [0:15] et = 16'b0100010001000001;
        logic [0:15] er = 16'b0111111001111111;
        do_reset;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        for (int i = 0; i < 16; i++) begin
            step;
            if (i == 0) cfg_valid = 1'b0;
            if (i == 6) begin cfg_valid = 1'b1; cfg_div = 8'd6; end
            if (i == 7) cfg_valid = 1'b0;
            checks++;
            if (clk_out[0] !== ec[i] || tick[0] !== et[i] || cfg_ready !== er[i]) begin
                errors++;
                $display("FAIL defer edge%0d clk_out=%b tick=%b ready=%b want %b/%b/%b",
                         i+1, clk_out[0], tick[0], cfg_ready, ec[i], et[i], er[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [0:13] ec = 14'b10001100001110;
        logic [0:13] et = 14'b01000010000001;
        logic [0:13] er = 14'b01000011111111;
        do_reset;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        for (int i = 0; i < 14; i++) begin
            step;
            if (i == 0) cfg_div = 8'd7;
            if (i == 2) cfg_valid = 1'b0;
            checks++;
            if (clk_out[0] !== ec[i] || tick[0] !== et[i] || cfg_ready !== er[i]) begin
                errors++;
                $display("FAIL b2b edge%0d clk_out=%b tick=%b ready=%b want %b/%b/%b",
                         i+1, clk_out[0], tick[0], cfg_ready, ec[i], et[i], er[i]);
            end
        end
    endtask

    task automatic test_stop_one_range;
        logic [0:9] ec = 10'b1000000000;
        logic [0:9] et = 10'b0100000111;
        logic [0:9] er = 10'b0111101111;
        do_reset;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (i == 0) cfg_valid = 1'b0;
            if (i == 4) begin cfg_valid = 1'b1; cfg_div = 8'd1; end
            if (i == 5) cfg_valid = 1'b0;
            checks++;
            if (clk_out[0] !== ec[i] || tick[0] !== et[i] || cfg_ready !== er[i]) begin
                errors++;
                $display("FAIL stop_one edge%0d clk_out=%b tick=%b ready=%b want %b/%b/%b",
                         i+1, clk_out[0], tick[0], cfg_ready, ec[i], et[i], er[i]);
            end
        end
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL range_ready got %b want 1", cfg_ready);
        end
        step;
        cfg_valid = 1'b0;
        checks++;
        if (clk_out !== 3'b110 || tick !== 3'b001) begin
            errors++;
            $display("FAIL range_edge11 clk_out=%b tick=%b want 110/001", clk_out, tick);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_ch = CH_W'(c);
            #1;
            checks++;
            if (cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL range_nopend ch%0d ready=%b want 1", c, cfg_ready);
            end
        end
        step;
        checks++;
        if (clk_out !== 3'b000 || tick !== 3'b111) begin
            errors++;
            $display("FAIL range_edge12 clk_out=%b tick=%b want 000/111", clk_out, tick);
        end
    endtask

    task automatic test_freeze_reset;
        logic [0:19] c0 = 20'b10011111110011001010;
        logic [0:19] t0 = 20'b01000000001000000101;
        logic [0:19] c1 = 20'b10100000010101001010;
        logic [0:19] t1 = 20'b01010000001010000101;
        logic [0:19] er = 20'b01111111111110111111;
        do_reset;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        for (int i = 0; i < 20; i++) begin
            step;
            if (i == 0)  cfg_valid = 1'b0;
            if (i == 3)  en = 1'b0;
            if (i == 8)  en = 1'b1;
            if (i == 12) begin cfg_valid = 1'b1; cfg_div = 8'd9; end
            if (i == 13) begin cfg_valid = 1'b0; reset = 1'b1; end
            if (i == 15) reset = 1'b0;
            checks++;
            if (clk_out[0] !== c0[i] || tick[0] !== t0[i] || cfg_ready !== er[i]) begin
                errors++;
                $display("FAIL freeze_ch0 edge%0d clk_out=%b tick=%b ready=%b want %b/%b/%b",
                         i+1, clk_out[0], tick[0], cfg_ready, c0[i], t0[i], er[i]);
            end
            checks++;
            if (clk_out[1] !== c1[i] || tick[1] !== t1[i]) begin
                errors++;
                $display("FAIL freeze_ch1 edge%0d clk_out=%b tick=%b want %b/%b",
                         i+1, clk_out[1], tick[1], c1[i], t1[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_idle_write;
        test_deferred_apply;
        test_back_to_back;
        test_stop_one_range;
        test_freeze_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Multi-channel programmable clock divider. Successor to the fixed /2, /4 divider.
Each of NUM_CH channels divides `clk` by a run-time divisor N and produces a divided-clock-enable square wave plus a one-cycle period tick.
Divisors are written through a valid/ready config port and take effect glitch-free at the channel's next period boundary.
Sits beside the system clock source and feeds slow-logic enables and baud/strobe generators.

Parameters:
NUM_CH, 2, number of independent divider channels (>=1)
DIV_W, 8, width of divisor and per-channel counter
DEFAULT_DIV, 2, divisor loaded into every channel at reset (0..2^DIV_W-1)
CH_W, max(1,$clog2(NUM_CH)), channel-select width (derived, not overridden)

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  global run enable; 0 freezes all channels
cfg_valid  input  1  config write request
cfg_ready  output  1  config write accepted when valid&&ready
cfg_ch  input  CH_W  target channel of config write
cfg_div  input  DIV_W  new divisor for target channel
clk_out  output  NUM_CH  divided square wave per channel (registered)
tick  output  NUM_CH  one-cycle pulse per channel, once per period (registered)

Behaviour:
- Per-channel state: `cnt[DIV_W]`, `div_act[DIV_W]`, `div_pend[DIV_W]`, `pend` flag.
- Reset (sync, overrides everything):
  - cnt=0, div_act=DEFAULT_DIV, pend=0, clk_out=0, tick=0.
  - Pending writes are discarded. Applies identically mid-operation.
- Running channel (en=1, div_act=N>=2):
  - cnt counts 0..N-1, then wraps to 0.
  - Define cnt_next as that counter value; L = ceil(N/2).
  - `clk_out <= (cnt_next >= L)`, giving low ceil(N/2) cycles and high floor(N/2) cycles.
  - N=2 matches the legacy /2 output: 0 during reset, 1 after the first edge, toggles every cycle.
- tick:
  - `tick <= (cnt == N-1)` while running, i.e. tick=1 in the cycle where cnt=0 after a wrap.
  - Exactly one pulse per N cycles; no tick on the first period after reset.
- N=1: tick=1 every cycle while en=1; clk_out held 0.
- N=0: channel stopped; cnt=0, clk_out=0, tick=0.
- en=0: every cnt and clk_out holds its value; tick forced 0.
- Config handshake:
  - `cfg_ready = !pend[cfg_ch]` (combinational from `cfg_ch`), or 1 if `cfg_ch >= NUM_CH`.
  - Accept when cfg_valid && cfg_ready: `div_pend <= cfg_div`, `pend <= 1`.
  - Writes to `cfg_ch >= NUM_CH` are accepted and dropped, with no state change.
- Apply pending divisor, in the first cycle where any of the following holds:
  - (a) en=1, running, and cnt==N-1, or
  - (b) div_act<=1, or
  - (c) en=0.
- On apply:
  - `div_act <= div_pend`, `cnt <= 0`, `clk_out <= 0`, `pend <= 0`.
  - Under (a), tick still fires for the completing old period.
  - The new period always begins in its low phase, so no runt pulse.
- Simultaneous events:
  - An accept to a channel and that channel's apply in the same cycle cannot occur, since ready=0 while pend=1.
  - The next write is accepted no earlier than the cycle after the apply.
  - Writes to different channels are independent.
- Latency: a write accepted at cycle t to an idle or stopped channel takes effect at t+1. For a running channel it takes effect at that channel's wrap.

Decomposition:
- Package `clk_div_pkg`:
  - DIV_W and NUM_CH defaults.
  - A `div_t` typedef (logic [DIV_W-1:0]).
  - Helper function `low_len(N) = (N+1)>>1`.
- Sub-module `clk_div_chan`, instantiated NUM_CH times via generate. It holds cnt, div_act, div_pend, pend, and the clk_out/tick registers.
- Top level does cfg_ch decode, the ready mux and the en fan-out.

Test Plan:
1. Reset held for 2 cycles, NUM_CH=2, DEFAULT_DIV=2, en=1 -> clk_out=0 and tick=0 during reset. Then both clk_out toggle every cycle (first rise on the first edge after release), and tick pulses every 2nd cycle.
2. Write ch1 div=3 while ch1 is idle at cnt=1 -> ch1 finishes its /2 period, then runs low 2 / high 1, tick every 3 cycles. ch0 is unaffected.
3. ch0 div=4 running, write div=6 at cnt=1 -> cfg_ready low for 2 cycles. The old period completes with its tick, then the pattern is low 3 / high 3. cfg_ready returns high the cycle after the apply.
4. Back-to-back writes to ch0 (div=5, then div=7) with cfg_valid held high -> the second write stalls until the first applies. The final steady pattern is 7 cycles: low 4 / high 3.
5. ch0 div=0 -> clk_out=0 and tick=0 from the next cycle. Then write div=1 -> tick=1 every cycle, clk_out=0. Write cfg_ch=3 -> accepted, no change.
6. en=0 for 5 cycles mid-period with div=4 -> cnt and clk_out frozen, tick=0, and the period resumes exactly on re-enable. Assert reset mid-period with a pending write -> all channels return to DEFAULT_DIV and the pending write is lost.
